// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] ALU_XOR  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_ADD  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_MULU = 4'b1010;
  localparam logic [3:0] ALU_DIVU = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// One shift register holds the multiplier or the dividend/quotient; acc holds the high half or remainder.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);
  localparam int CW = $clog2(WIDTH);

  logic             run_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic [WIDTH-1:0] opnd_q, acc_q, sh_q;
  logic [WIDTH-1:0] acc_d, sh_d;
  logic [WIDTH:0]   sum, rem_sh, diff;

  always_comb begin
    sum    = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {acc_q, sh_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    acc_d  = acc_q;
    sh_d   = sh_q;
    if (div_q) begin
      // Remainder stays below the divisor, so bit WIDTH of diff is a clean borrow flag.
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = sum[WIDTH:1];
      sh_d  = {sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // The final step's result is presented combinationally so the top captures it on the same edge.
  assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign lo_o   = sh_d;
  assign hi_o   = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      div_q  <= div_i;
      opnd_q <= div_i ? b_i : a_i;
      sh_q   <= div_i ? a_i : b_i;
      acc_q  <= '0;
    end else if (run_q) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with IDLE/BUSY/DONE control; one op in flight at a time.
// Define ALU_MULDIV_EN to add iterative MULU/DIVU; otherwise those codes behave as unsupported ops.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  function automatic logic [WIDTH-1:0] alu_1cyc(input logic [3:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [SHW-1:0]          sh;
    logic signed [WIDTH-1:0] xs;
    logic [WIDTH-1:0]        r;
    sh = y[SHW-1:0];
    xs = $signed(x);
    r  = '0;
    case (f)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_XOR: r = x ^ y;
      ALU_NOR: r = ~(x | y);
      ALU_SLL: r = x << sh;
      ALU_SRL: r = x >> sh;
      ALU_SRA: r = xs >>> sh;
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, (x < y)};
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_MULDIV_EN
  logic             md_start, md_done, is_md;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign is_md = (op == ALU_MULU) || (op == ALU_DIVU);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .div_i   (op == ALU_DIVU),
    .a_i     (a),
    .b_i     (b),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
`ifdef ALU_MULDIV_EN
    md_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MULDIV_EN
          if (is_md) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            result_d = alu_1cyc(op, a, b);
            hi_d     = '0;
            state_d  = ST_DONE;
          end
`else
          result_d = alu_1cyc(op, a, b);
          hi_d     = '0;
          state_d  = ST_DONE;
`endif
        end
      end
      ST_BUSY: begin
`ifdef ALU_MULDIV_EN
        if (md_done) begin
          result_d = md_lo;
          hi_d     = md_hi;
          state_d  = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign result_hi = hi_q;
  assign zero      = (result_q == '0);

endmodule
